branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
Sits downstream of the BHT/BTB predictor and closes its loop.
- Carries each fetch-stage prediction (taken flag, predicted target) alongside the instruction through D and E.
- Compares the prediction against the actual outcome resolved in E.
- Issues the predictor's training write-enables and the pipeline redirect/flush on a misprediction.

Parameters:
ENTRY_BITS, 8, predictor index width; index = PC[ENTRY_BITS+1:2]
RECOVER_CYCLES, 1, cycles resolution is suppressed after a redirect (1..3)

Ports:
clk  in  1  clock, rising edge
nrst  in  1  asynchronous active-low reset
PC_F  in  32  fetch PC
PrPCSrc_F  in  1  predicted taken at F
PrALUResult_F  in  32  predicted target at F
StallD  in  1  hold D regs
FlushD  in  1  hazard-unit flush of D regs
StallE  in  1  hold E regs
FlushE  in  1  hazard-unit flush of E regs
Branch_E  in  1  instruction in E is a branch
PCSrc_E  in  1  actual taken (condition passed)
ALUResult_E  in  32  actual target
PC_plus4_E  in  32  fall-through address of E instruction
PC_E  out  ENTRY_BITS  predictor index of E instruction
WE_PrPCSrc  out  1  train 2-bit counter
WE_PrALUResult  out  1  write BTB target
Mispredict_E  out  1  redirect fetch this cycle
PC_Redirect  out  32  correct next PC when Mispredict_E=1
BrFlush  out  1  flush D and E next edge (=Mispredict_E)

Behaviour:
- Pipeline regs PrPCSrc_D/E, PrTA_D/E, PCidx_D/E: D captures F values, E captures D values.
  - Priority per stage: reset > (FlushX | BrFlush) > StallX > load.
  - Flush clears taken flag, target and index to 0.
- Reset: every register and state = 0/IDLE.
  - All outputs 0 in reset. PC_E=0; other outputs are combinational from E regs and are 0 while E regs are 0.
- Resolution is combinational in E; it is qualified by state==IDLE and !StallE.
  - Let valid = Branch_E | PrPCSrc_E. Non-branch aliases that were predicted taken must be corrected.
  - WE_PrPCSrc = valid. Trains on every resolved branch or alias; predictor taken input = PCSrc_E & Branch_E.
  - WE_PrALUResult = Branch_E & PCSrc_E & (!PrPCSrc_E | PrTA_E != ALUResult_E).
- Mispredict cases (PC_Redirect in each):
  - Predicted taken, actual not-taken or non-branch -> PC_plus4_E.
  - Predicted not-taken, actual taken -> ALUResult_E.
  - Both taken, target differs -> ALUResult_E.
  - Otherwise Mispredict_E=0 and PC_Redirect=0.
- Latency: redirect asserted in the same cycle the branch is in E. The fetch mux uses it at the next edge, so the penalty is 2 cycles.
- FSM:
  - IDLE -> RECOVER on Mispredict_E. Counter loads RECOVER_CYCLES-1.
  - RECOVER: outputs suppressed; counter decrements; -> IDLE at 0.
  - The flushed bubbles in E can never produce a second redirect.
- Simultaneous events:
  - FlushE with a resolving branch: the resolution is still honoured, because flush takes effect on the edge.
  - StallE: no write-enables and no redirect; the branch resolves once when the stall releases.
- Reset mid-RECOVER: returns to IDLE immediately.
- Equality compare is full 32-bit. No arithmetic wrap concerns.

Optional Feature:
BRU_PERF_CNT_EN.
- With the macro: adds outputs BrCount[31:0] and MissCount[31:0].
  - BrCount increments on WE_PrPCSrc & Branch_E; MissCount increments on Mispredict_E.
  - Both are saturating at 32'hFFFFFFFF and reset to 0.
- Without the macro: the ports and counters are absent. Core behaviour is identical.

Decomposition:
- Shared package holds:
  - the ENTRY_BITS default;
  - FSM state encoding IDLE=1'b0, RECOVER=1'b1;
  - the 32-bit address width constant.
- One sub-module: bru_pred_pipe. It is a single stage register (flag, target, index) with stall/flush and is instantiated twice, for D and E.

Test Plan:
- Correct prediction: loop branch at PC 0x40 predicted taken to 0x20, actual taken to 0x20 -> WE_PrPCSrc=1, WE_PrALUResult=0, Mispredict_E=0.
- Cold miss: PrPCSrc_F=0, actual taken to 0x100 at PC 0x40 -> PC_E=0x10, WE_PrALUResult=1, Mispredict_E=1, PC_Redirect=0x100, FSM RECOVER for 1 cycle.
- Wrong direction: predicted taken to 0x20, PCSrc_E=0, PC_plus4_E=0x44 -> PC_Redirect=0x44, WE_PrALUResult=0.
- Wrong target and alias:
  - Predicted 0x20, actual 0x80 -> redirect 0x80 and BTB write.
  - Non-branch predicted taken -> redirect PC+4, WE_PrPCSrc=1 with taken=0.
- Stall/flush: StallE held 3 cycles on a mispredicting branch -> single redirect pulse after release. Back-to-back branches: the second one, landing in RECOVER, produces no outputs.
- Async reset asserted during RECOVER -> all outputs 0 immediately; with BRU_PERF_CNT_EN, counters read 0.

Source files
------------

// File: rtl/branch_resolve_unit_pkg.sv
// Shared constants and FSM encoding for the branch resolve unit.
package branch_resolve_unit_pkg;

  localparam int unsigned ENTRY_BITS_DEF = 8;
  localparam int unsigned ADDR_W         = 32;

  typedef enum logic {
    IDLE    = 1'b0,
    RECOVER = 1'b1
  } bru_state_e;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Pipeline-side bundle of the branch resolve unit; optional perf counters
// are present only when BRU_PERF_CNT_EN is defined.
interface branch_resolve_unit_if
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned ENTRY_BITS = ENTRY_BITS_DEF
);

  logic [ADDR_W-1:0]     PC_F;
  logic                  PrPCSrc_F;
  logic [ADDR_W-1:0]     PrALUResult_F;
  logic                  StallD;
  logic                  FlushD;
  logic                  StallE;
  logic                  FlushE;
  logic                  Branch_E;
  logic                  PCSrc_E;
  logic [ADDR_W-1:0]     ALUResult_E;
  logic [ADDR_W-1:0]     PC_plus4_E;
  logic [ENTRY_BITS-1:0] PC_E;
  logic                  WE_PrPCSrc;
  logic                  WE_PrALUResult;
  logic                  Mispredict_E;
  logic [ADDR_W-1:0]     PC_Redirect;
  logic                  BrFlush;
`ifdef BRU_PERF_CNT_EN
  logic [31:0]           BrCount;
  logic [31:0]           MissCount;

  modport slave (
    input  PC_F, PrPCSrc_F, PrALUResult_F, StallD, FlushD, StallE, FlushE,
           Branch_E, PCSrc_E, ALUResult_E, PC_plus4_E,
    output PC_E, WE_PrPCSrc, WE_PrALUResult, Mispredict_E, PC_Redirect, BrFlush,
           BrCount, MissCount
  );
  modport master (
    output PC_F, PrPCSrc_F, PrALUResult_F, StallD, FlushD, StallE, FlushE,
           Branch_E, PCSrc_E, ALUResult_E, PC_plus4_E,
    input  PC_E, WE_PrPCSrc, WE_PrALUResult, Mispredict_E, PC_Redirect, BrFlush,
           BrCount, MissCount
  );
`else
  modport slave (
    input  PC_F, PrPCSrc_F, PrALUResult_F, StallD, FlushD, StallE, FlushE,
           Branch_E, PCSrc_E, ALUResult_E, PC_plus4_E,
    output PC_E, WE_PrPCSrc, WE_PrALUResult, Mispredict_E, PC_Redirect, BrFlush
  );
  modport master (
    output PC_F, PrPCSrc_F, PrALUResult_F, StallD, FlushD, StallE, FlushE,
           Branch_E, PCSrc_E, ALUResult_E, PC_plus4_E,
    input  PC_E, WE_PrPCSrc, WE_PrALUResult, Mispredict_E, PC_Redirect, BrFlush
  );
`endif

endinterface

// File: rtl/branch_resolve_unit_pred_pipe.sv
// One pipeline stage of prediction side-band (taken flag, target, index)
// with flush-over-stall priority.
module bru_pred_pipe
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned IDX_W = ENTRY_BITS_DEF
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              flag_i,
  input  logic [ADDR_W-1:0] target_i,
  input  logic [IDX_W-1:0]  idx_i,
  output logic              flag_o,
  output logic [ADDR_W-1:0] target_o,
  output logic [IDX_W-1:0]  idx_o
);

  logic              flag_q,   flag_d;
  logic [ADDR_W-1:0] target_q, target_d;
  logic [IDX_W-1:0]  idx_q,    idx_d;

  always_comb begin
    flag_d   = flag_q;
    target_d = target_q;
    idx_d    = idx_q;
    if (flush_i) begin
      flag_d   = 1'b0;
      target_d = '0;
      idx_d    = '0;
    end else if (!stall_i) begin
      flag_d   = flag_i;
      target_d = target_i;
      idx_d    = idx_i;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      flag_q   <= 1'b0;
      target_q <= '0;
      idx_q    <= '0;
    end else begin
      flag_q   <= flag_d;
      target_q <= target_d;
      idx_q    <= idx_d;
    end
  end

  assign flag_o   = flag_q;
  assign target_o = target_q;
  assign idx_o    = idx_q;

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves fetch-stage predictions in E, trains the BHT/BTB and redirects fetch.
// Optional BRU_PERF_CNT_EN adds saturating branch/mispredict counters.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned ENTRY_BITS     = ENTRY_BITS_DEF,
  parameter int unsigned RECOVER_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 nrst,
  branch_resolve_unit_if.slave bus
);

  logic                  pr_d, pr_e;
  logic [ADDR_W-1:0]     ta_d, ta_e;
  logic [ENTRY_BITS-1:0] idx_d, idx_e;
  logic                  br_flush;

  bru_pred_pipe #(.IDX_W(ENTRY_BITS)) u_pipe_d (
    .clk      (clk),
    .nrst     (nrst),
    .stall_i  (bus.StallD),
    .flush_i  (bus.FlushD | br_flush),
    .flag_i   (bus.PrPCSrc_F),
    .target_i (bus.PrALUResult_F),
    .idx_i    (bus.PC_F[ENTRY_BITS+1:2]),
    .flag_o   (pr_d),
    .target_o (ta_d),
    .idx_o    (idx_d)
  );

  bru_pred_pipe #(.IDX_W(ENTRY_BITS)) u_pipe_e (
    .clk      (clk),
    .nrst     (nrst),
    .stall_i  (bus.StallE),
    .flush_i  (bus.FlushE | br_flush),
    .flag_i   (pr_d),
    .target_i (ta_d),
    .idx_i    (idx_d),
    .flag_o   (pr_e),
    .target_o (ta_e),
    .idx_o    (idx_e)
  );

  bru_state_e        state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              active, act_taken, tgt_diff;
  logic              we_pc, we_ta, mis;
  logic [ADDR_W-1:0] redir;

  // Gating with nrst keeps every output low while reset is asserted,
  // even if the E-stage inputs from upstream are still toggling.
  always_comb begin
    active    = nrst && (state_q == IDLE) && !bus.StallE;
    act_taken = bus.Branch_E & bus.PCSrc_E;
    tgt_diff  = (ta_e != bus.ALUResult_E);
    we_pc     = 1'b0;
    we_ta     = 1'b0;
    mis       = 1'b0;
    redir     = '0;
    if (active) begin
      we_pc = bus.Branch_E | pr_e;
      we_ta = act_taken & (!pr_e | tgt_diff);
      if (pr_e && !act_taken) begin
        mis   = 1'b1;
        redir = bus.PC_plus4_E;
      end else if (we_ta) begin
        mis   = 1'b1;
        redir = bus.ALUResult_E;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (mis) begin
          state_d = RECOVER;
          cnt_d   = 2'(RECOVER_CYCLES - 1);
        end
      end
      RECOVER: begin
        if (cnt_q == 2'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 2'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign br_flush           = mis;
  assign bus.PC_E           = idx_e;
  assign bus.WE_PrPCSrc     = we_pc;
  assign bus.WE_PrALUResult = we_ta;
  assign bus.Mispredict_E   = mis;
  assign bus.PC_Redirect    = redir;
  assign bus.BrFlush        = br_flush;

`ifdef BRU_PERF_CNT_EN
  logic [31:0] br_cnt_q, br_cnt_d, miss_cnt_q, miss_cnt_d;

  always_comb begin
    br_cnt_d   = br_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (we_pc && bus.Branch_E && (br_cnt_q != '1)) br_cnt_d = br_cnt_q + 32'd1;
    if (mis && (miss_cnt_q != '1))                  miss_cnt_d = miss_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      br_cnt_q   <= '0;
      miss_cnt_q <= '0;
    end else begin
      br_cnt_q   <= br_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign bus.BrCount   = br_cnt_q;
  assign bus.MissCount = miss_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed test-plan cases then random traffic.
module tb_branch_resolve_unit;

  localparam int unsigned RC = 1;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  branch_resolve_unit_if #(.ENTRY_BITS(8)) bus ();

  branch_resolve_unit #(.ENTRY_BITS(8), .RECOVER_CYCLES(RC)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus.slave)
  );

  typedef struct packed {
    logic        f;
    logic [31:0] t;
    logic [7:0]  i;
  } slot_t;

  typedef struct packed {
    logic [7:0]  pce;
    logic        we;
    logic        wta;
    logic        mis;
    logic [31:0] red;
    logic [31:0] brc;
    logic [31:0] missc;
  } exp_t;

  int total = 0;
  int bad   = 0;
  exp_t sb[$];

  slot_t       m_d, m_e;
  int          sup;
  logic [31:0] m_brc, m_missc;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
    end
  endtask

  function automatic void model_reset();
    m_d = '0; m_e = '0; sup = 0; m_brc = '0; m_missc = '0;
  endfunction

  // Compare predicted next-PC against actual next-PC in terms of direction and target.
  function automatic exp_t predict();
    exp_t        e;
    logic        resolves, actual_taken;
    e          = '0;
    e.pce      = m_e.i;
    e.brc      = m_brc;
    e.missc    = m_missc;
    resolves   = (sup == 0) && !bus.StallE;
    actual_taken = bus.Branch_E && bus.PCSrc_E;
    if (resolves && (bus.Branch_E || m_e.f)) begin
      e.we  = 1'b1;
      e.wta = actual_taken && (!m_e.f || m_e.t != bus.ALUResult_E);
      e.mis = (m_e.f != actual_taken) || (actual_taken && m_e.t != bus.ALUResult_E);
      if (e.mis) e.red = actual_taken ? bus.ALUResult_E : bus.PC_plus4_E;
    end
    return e;
  endfunction

  function automatic void model_edge(input exp_t e);
    slot_t nd, ne;
    ne = (bus.FlushE || e.mis) ? '0 : (bus.StallE ? m_e : m_d);
    nd = (bus.FlushD || e.mis) ? '0 :
         (bus.StallD ? m_d : {bus.PrPCSrc_F, bus.PrALUResult_F, bus.PC_F[9:2]});
    if (e.mis) sup = RC;
    else if (sup > 0) sup--;
    if (e.we && bus.Branch_E && m_brc != 32'hFFFF_FFFF) m_brc++;
    if (e.mis && m_missc != 32'hFFFF_FFFF) m_missc++;
    m_d = nd;
    m_e = ne;
  endfunction

  task automatic cycle(input logic [31:0] pcf, input logic prf, input logic [31:0] taf,
                       input logic sd, input logic fd, input logic se, input logic fe,
                       input logic be, input logic pse, input logic [31:0] alu,
                       input logic [31:0] p4);
    exp_t e;
    bus.PC_F = pcf; bus.PrPCSrc_F = prf; bus.PrALUResult_F = taf;
    bus.StallD = sd; bus.FlushD = fd; bus.StallE = se; bus.FlushE = fe;
    bus.Branch_E = be; bus.PCSrc_E = pse; bus.ALUResult_E = alu; bus.PC_plus4_E = p4;
    e = predict();
    sb.push_back(e);
    @(posedge clk);
    model_edge(e);
    #1;
  endtask

  task automatic idle_cycle();
    cycle('0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  // Fetch, decode, then resolve in E with the given actual outcome.
  task automatic issue(input logic [31:0] pc, input logic pr, input logic [31:0] ta,
                       input logic br, input logic tk, input logic [31:0] alu);
    cycle(pc, pr, ta, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    idle_cycle();
    cycle('0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, br, tk, alu, pc + 32'd4);
    idle_cycle();
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("PC_E", 32'(bus.PC_E), 32'(e.pce));
      check("WE_PrPCSrc", 32'(bus.WE_PrPCSrc), 32'(e.we));
      check("WE_PrALUResult", 32'(bus.WE_PrALUResult), 32'(e.wta));
      check("Mispredict_E", 32'(bus.Mispredict_E), 32'(e.mis));
      check("BrFlush", 32'(bus.BrFlush), 32'(e.mis));
      check("PC_Redirect", bus.PC_Redirect, e.red);
`ifdef BRU_PERF_CNT_EN
      check("BrCount", bus.BrCount, e.brc);
      check("MissCount", bus.MissCount, e.missc);
`endif
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_PC_E"}, 32'(bus.PC_E), 32'd0);
    check({tag, "_WE_PrPCSrc"}, 32'(bus.WE_PrPCSrc), 32'd0);
    check({tag, "_WE_PrALUResult"}, 32'(bus.WE_PrALUResult), 32'd0);
    check({tag, "_Mispredict_E"}, 32'(bus.Mispredict_E), 32'd0);
    check({tag, "_PC_Redirect"}, bus.PC_Redirect, 32'd0);
    check({tag, "_BrFlush"}, 32'(bus.BrFlush), 32'd0);
`ifdef BRU_PERF_CNT_EN
    check({tag, "_BrCount"}, bus.BrCount, 32'd0);
    check({tag, "_MissCount"}, bus.MissCount, 32'd0);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    nrst = 1'b0;
    bus.PC_F = '0; bus.PrPCSrc_F = 1'b0; bus.PrALUResult_F = '0;
    bus.StallD = 1'b0; bus.FlushD = 1'b0; bus.StallE = 1'b0; bus.FlushE = 1'b0;
    bus.Branch_E = 1'b0; bus.PCSrc_E = 1'b0; bus.ALUResult_E = '0; bus.PC_plus4_E = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    nrst = 1'b1;

    // Correct prediction, cold miss, wrong direction, wrong target, alias.
    issue(32'h40, 1'b1, 32'h20, 1'b1, 1'b1, 32'h20);
    issue(32'h40, 1'b0, 32'h0,  1'b1, 1'b1, 32'h100);
    issue(32'h40, 1'b1, 32'h20, 1'b1, 1'b0, 32'h20);
    issue(32'h40, 1'b1, 32'h20, 1'b1, 1'b1, 32'h80);
    issue(32'h84, 1'b1, 32'h20, 1'b0, 1'b0, 32'h55);

    // StallE held 3 cycles on a mispredicting branch.
    cycle(32'h40, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    idle_cycle();
    repeat (3) cycle('0, 1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 32'h44);
    cycle('0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h100, 32'h44);
    idle_cycle();

    // Back-to-back branches: the second lands in RECOVER.
    cycle(32'h40, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    cycle(32'h48, 1'b1, 32'h30, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    cycle('0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h100, 32'h44);
    cycle('0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h30, 32'h4c);
    idle_cycle();

    // FlushE together with a resolving branch.
    cycle(32'h60, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    idle_cycle();
    cycle('0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h200, 32'h64);
    idle_cycle();

    // Async reset in the middle of RECOVER.
    cycle(32'h40, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    idle_cycle();
    cycle('0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h100, 32'h44);
    bus.Branch_E = 1'b1; bus.PCSrc_E = 1'b1; bus.ALUResult_E = 32'h1234;
    bus.PC_plus4_E = 32'h44;
    #1;
    nrst = 1'b0;
    #1;
    check_all_zero("rst_recover");
    @(posedge clk);
    #1;
    model_reset();
    nrst = 1'b1;
    idle_cycle();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] pcf, taf, alu, p4;
      logic        prf, sd, fd, se, fe, be, pse;
      pcf = {$urandom_range(0, 1023), 2'b00};
      prf = ($urandom_range(0, 1) == 1);
      taf = {$urandom_range(0, 63), 2'b00};
      sd  = ($urandom_range(0, 7) == 0);
      fd  = ($urandom_range(0, 11) == 0);
      se  = ($urandom_range(0, 7) == 0);
      fe  = ($urandom_range(0, 11) == 0);
      be  = ($urandom_range(0, 2) != 0);
      pse = ($urandom_range(0, 1) == 1);
      alu = ($urandom_range(0, 1) == 1) ? m_e.t : {$urandom_range(0, 63), 2'b00};
      p4  = {$urandom_range(0, 1023), 2'b00};
      cycle(pcf, prf, taf, sd, fd, se, fe, be, pse, alu, p4);
    end
    idle_cycle();
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
